lsu_mem_master: RTL

- Load/store initiator that drives the single-port word RAM from the core side.
- Accepts byte-addressed load/store requests of byte, half or word size.
- Generates word address, byte-lane write strobes and shifted write data.
- Absorbs the RAM's 1-cycle registered read latency, splits word-crossing (misaligned) accesses into two RAM accesses, and returns sign- or zero-extended load data.

---
 rtl/lsu_mem_master.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_master.sv
// -----------------------------------------------------------------------------
// lsu_mem_master
//
// Load/store initiator for a single-port, word-wide RAM that has a
// registered read (data appears the cycle after mem_read is sampled).
// It takes byte-addressed byte/half/word requests from the core and turns
// them into word accesses. A request that crosses a word boundary is split
// into two accesses. Load data comes back sign- or zero-extended.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE. Once a request is
// accepted, the block is busy until its single-cycle rsp_valid pulse.
// req_ready rises in that same cycle, so a new request can transfer there.
// req_valid raised while req_ready is 0 is ignored, and nothing is latched.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   req_*          request: valid/ready, we (1=store), size (00 byte,
//                  01 half, 1x word), unsigned (zero-extend loads),
//                  byte address, right-justified store data
//   rsp_valid      one-cycle completion pulse for loads and stores
//   rsp_rdata      extended load data. Set to 0 by store responses and
//                  held between responses.
//   mem_addr       RAM word address
//   mem_read       RAM read enable
//   mem_write      RAM byte-lane write strobes (bit i -> bits 8i+7:8i)
//   mem_wdata      RAM write data, already shifted into lanes
//   mem_rdata      RAM read data, valid the cycle after mem_read
//
// FSM: IDLE -> A1 (first access on the bus)
//           -> A2 (second access, split requests only)
//           -> LW (load only: final read word arriving) -> IDLE
// All outputs are registered.
// -----------------------------------------------------------------------------
module lsu_mem_master #(
    parameter int WORD_AW = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic               req_unsigned,
    input  logic [WORD_AW+1:0] req_addr,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic [WORD_AW-1:0] mem_addr,
    output logic               mem_read,
    output logic [3:0]         mem_write,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        A1   = 2'd1,
        A2   = 2'd2,
        LW   = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Request fields latched at accept time.
    logic        lat_we,       lat_we_nxt;
    logic        lat_unsigned, lat_unsigned_nxt;
    logic [1:0]  lat_size,     lat_size_nxt;
    logic [1:0]  lat_off,      lat_off_nxt;
    logic        lat_split,    lat_split_nxt;
    logic [3:0]  lat_strb2,    lat_strb2_nxt;
    logic [31:0] lat_wdata2,   lat_wdata2_nxt;
    logic [31:0] lo_word,      lo_word_nxt;

    // Next values of the registered outputs.
    logic               req_ready_nxt;
    logic               rsp_valid_nxt;
    logic [31:0]        rsp_rdata_nxt;
    logic [WORD_AW-1:0] mem_addr_nxt;
    logic               mem_read_nxt;
    logic [3:0]         mem_write_nxt;
    logic [31:0]        mem_wdata_nxt;

    // ---------------------------------------------------------------------
    // Request decode. The strobe and the data are shifted once, into double
    // width. The low half is access 1 (word A). The high half is whatever
    // spills into word A+1, so it is access 2 of a split store.
    // ---------------------------------------------------------------------
    logic [2:0]  req_n;
    logic [3:0]  req_mask;
    logic [7:0]  req_strb;
    logic [63:0] req_data;
    logic        req_split;

    always_comb begin
        case (req_size)
            2'b00: begin
                req_n    = 3'd1;
                req_mask = 4'b0001;
            end
            2'b01: begin
                req_n    = 3'd2;
                req_mask = 4'b0011;
            end
            default: begin
                req_n    = 3'd4;
                req_mask = 4'b1111;
            end
        endcase
        req_strb  = {4'b0000, req_mask} << req_addr[1:0];
        req_data  = {32'd0, req_wdata} << {req_addr[1:0], 3'b000};
        req_split = (({1'b0, req_addr[1:0]} + req_n) > 3'd4);
    end

    // ---------------------------------------------------------------------
    // Load assembly. It is only used in LW, where mem_rdata is the final
    // word. For a split load that word is the upper word, and the lower one
    // was captured in A2. A non-split load uses a zero upper word.
    // ---------------------------------------------------------------------
    logic [31:0] asm_hi;
    logic [31:0] asm_lo;
    logic [31:0] asm_shift;
    logic [31:0] asm_word;

    always_comb begin
        asm_hi    = lat_split ? mem_rdata : 32'd0;
        asm_lo    = lat_split ? lo_word   : mem_rdata;
        asm_shift = 32'({asm_hi, asm_lo} >> {lat_off, 3'b000});
        case (lat_size)
            2'b00:   asm_word = {{24{asm_shift[7]  & ~lat_unsigned}}, asm_shift[7:0]};
            2'b01:   asm_word = {{16{asm_shift[15] & ~lat_unsigned}}, asm_shift[15:0]};
            default: asm_word = asm_shift;
        endcase
    end

    // ---------------------------------------------------------------------
    // Next-state and next-output logic.
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt        = state;
        lat_we_nxt       = lat_we;
        lat_unsigned_nxt = lat_unsigned;
        lat_size_nxt     = lat_size;
        lat_off_nxt      = lat_off;
        lat_split_nxt    = lat_split;
        lat_strb2_nxt    = lat_strb2;
        lat_wdata2_nxt   = lat_wdata2;
        lo_word_nxt      = lo_word;
        req_ready_nxt    = req_ready;
        rsp_valid_nxt    = 1'b0;
        rsp_rdata_nxt    = rsp_rdata;
        mem_addr_nxt     = mem_addr;
        mem_wdata_nxt    = mem_wdata;
        // The bus is idle unless an access is issued below.
        mem_read_nxt     = 1'b0;
        mem_write_nxt    = 4'b0000;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    lat_we_nxt       = req_we;
                    lat_unsigned_nxt = req_unsigned;
                    lat_size_nxt     = req_size;
                    lat_off_nxt      = req_addr[1:0];
                    lat_split_nxt    = req_split;
                    lat_strb2_nxt    = req_strb[7:4];
                    lat_wdata2_nxt   = req_data[63:32];
                    mem_addr_nxt     = req_addr[WORD_AW+1:2];
                    mem_read_nxt     = ~req_we;
                    mem_write_nxt    = req_we ? req_strb[3:0] : 4'b0000;
                    if (req_we) begin
                        mem_wdata_nxt = req_data[31:0];
                    end
                    req_ready_nxt    = 1'b0;
                    state_nxt        = A1;
                end
            end

            A1: begin
                if (lat_split) begin
                    // The increment wraps at the top of memory, back to word 0.
                    mem_addr_nxt  = mem_addr + WORD_AW'(1);
                    mem_read_nxt  = ~lat_we;
                    mem_write_nxt = lat_we ? lat_strb2 : 4'b0000;
                    if (lat_we) begin
                        mem_wdata_nxt = lat_wdata2;
                    end
                    state_nxt     = A2;
                end else if (lat_we) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = 32'd0;
                    req_ready_nxt = 1'b1;
                    state_nxt     = IDLE;
                end else begin
                    state_nxt     = LW;
                end
            end

            A2: begin
                if (lat_we) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = 32'd0;
                    req_ready_nxt = 1'b1;
                    state_nxt     = IDLE;
                end else begin
                    // The read of word A issued in A1 is arriving now.
                    lo_word_nxt   = mem_rdata;
                    state_nxt     = LW;
                end
            end

            LW: begin
                rsp_valid_nxt = 1'b1;
                rsp_rdata_nxt = asm_word;
                req_ready_nxt = 1'b1;
                state_nxt     = IDLE;
            end

            default: begin
                req_ready_nxt = 1'b1;
                state_nxt     = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State and output registers.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lat_we       <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_size     <= 2'b00;
            lat_off      <= 2'b00;
            lat_split    <= 1'b0;
            lat_strb2    <= 4'b0000;
            lat_wdata2   <= 32'd0;
            lo_word      <= 32'd0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'd0;
            mem_addr     <= '0;
            mem_read     <= 1'b0;
            mem_write    <= 4'b0000;
            mem_wdata    <= 32'd0;
        end else begin
            state        <= state_nxt;
            lat_we       <= lat_we_nxt;
            lat_unsigned <= lat_unsigned_nxt;
            lat_size     <= lat_size_nxt;
            lat_off      <= lat_off_nxt;
            lat_split    <= lat_split_nxt;
            lat_strb2    <= lat_strb2_nxt;
            lat_wdata2   <= lat_wdata2_nxt;
            lo_word      <= lo_word_nxt;
            req_ready    <= req_ready_nxt;
            rsp_valid    <= rsp_valid_nxt;
            rsp_rdata    <= rsp_rdata_nxt;
            mem_addr     <= mem_addr_nxt;
            mem_read     <= mem_read_nxt;
            mem_write    <= mem_write_nxt;
            mem_wdata    <= mem_wdata_nxt;
        end
    end

endmodule
